// File: rtl/rv32i_decode_exec_unit.sv
// ============================================================================
// rv32i_decode_exec_unit -- RV32I decode plus registered ALU/branch-compare slice
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module rv32i_decode_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] insn_i,
  input  logic [31:0] rs1_val_i,
  input  logic [31:0] rs2_val_i,
  output logic [4:0]  opcode_o,
  output logic [3:0]  alu_op_o,
  output logic        invalid_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [31:0] imm_o,
  output logic [31:0] alu_result_o,
  output logic        branch_taken_o
);

  localparam logic [4:0] c_OPC_LOAD     = 5'b00000;
  localparam logic [4:0] c_OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] c_OPC_ALUIMM   = 5'b00100;
  localparam logic [4:0] c_OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] c_OPC_STORE    = 5'b01000;
  localparam logic [4:0] c_OPC_OP       = 5'b01100;
  localparam logic [4:0] c_OPC_LUI      = 5'b01101;
  localparam logic [4:0] c_OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] c_OPC_JALR     = 5'b11001;
  localparam logic [4:0] c_OPC_JAL      = 5'b11011;
  localparam logic [4:0] c_OPC_SYSTEM   = 5'b11100;

  localparam logic [3:0] c_ALU_ADD  = 4'b0000;
  localparam logic [3:0] c_ALU_SUB  = 4'b1000;
  localparam logic [3:0] c_ALU_SLL  = 4'b0001;
  localparam logic [3:0] c_ALU_SLT  = 4'b0010;
  localparam logic [3:0] c_ALU_SLTU = 4'b0011;
  localparam logic [3:0] c_ALU_XOR  = 4'b0100;
  localparam logic [3:0] c_ALU_SRL  = 4'b0101;
  localparam logic [3:0] c_ALU_SRA  = 4'b1101;
  localparam logic [3:0] c_ALU_OR   = 4'b0110;
  localparam logic [3:0] c_ALU_AND  = 4'b0111;

  logic [4:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_invalid;
  logic [31:0] w_imm;
  logic [3:0]  w_alu_op;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [4:0]  w_shamt;

  logic [31:0] alu_result_d, alu_result_q;
  logic        branch_taken_d, branch_taken_q;

  assign w_opcode = insn_i[6:2];
  assign w_funct3 = insn_i[14:12];
  assign w_funct7 = insn_i[31:25];

  // Legality check
  always_comb begin
    w_invalid = 1'b0;
    case (w_opcode)
      c_OPC_LOAD, c_OPC_MISC_MEM, c_OPC_AUIPC, c_OPC_STORE,
      c_OPC_LUI, c_OPC_JALR, c_OPC_JAL, c_OPC_SYSTEM: w_invalid = 1'b0;
      c_OPC_BRANCH: w_invalid = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      c_OPC_OP: begin
        if (w_funct7 == 7'h20)
          w_invalid = (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
        else
          w_invalid = (w_funct7 != 7'h00);
      end
      c_OPC_ALUIMM: begin
        if (w_funct3 == 3'b001)
          w_invalid = (w_funct7 != 7'h00);
        else if (w_funct3 == 3'b101)
          w_invalid = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
        else
          w_invalid = 1'b0;
      end
      default: w_invalid = 1'b1;
    endcase
    if (insn_i[1:0] != 2'b11)
      w_invalid = 1'b1;
  end

  // Immediate formats; OP and unlisted opcodes carry no immediate
  always_comb begin
    w_imm = 32'h0;
    case (w_opcode)
      c_OPC_LOAD, c_OPC_ALUIMM, c_OPC_JALR, c_OPC_SYSTEM:
        w_imm = {{20{insn_i[31]}}, insn_i[31:20]};
      c_OPC_STORE:
        w_imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      c_OPC_BRANCH:
        w_imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
      c_OPC_AUIPC, c_OPC_LUI:
        w_imm = {insn_i[31:12], 12'h000};
      c_OPC_JAL:
        w_imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
      default:
        w_imm = 32'h0;
    endcase
  end

  always_comb begin
    w_alu_op = c_ALU_ADD;
    if (w_opcode == c_OPC_OP)
      w_alu_op = {insn_i[30], w_funct3};
    else if (w_opcode == c_OPC_ALUIMM)
      w_alu_op = {insn_i[30] & (w_funct3 == 3'b101), w_funct3};
  end

  // JALR passes rs1 through untouched; the core adds the offset for the target
  always_comb begin
    w_op_a = (w_opcode == c_OPC_LUI) ? 32'h0 : rs1_val_i;
    case (w_opcode)
      c_OPC_ALUIMM, c_OPC_LUI, c_OPC_LOAD, c_OPC_STORE: w_op_b = w_imm;
      c_OPC_JALR:                                       w_op_b = 32'h0;
      default:                                          w_op_b = rs2_val_i;
    endcase
  end

  assign w_shamt = w_op_b[4:0];

  always_comb begin
    alu_result_d = 32'h0;
    case (w_alu_op)
      c_ALU_ADD:  alu_result_d = w_op_a + w_op_b;
      c_ALU_SUB:  alu_result_d = w_op_a - w_op_b;
      c_ALU_SLL:  alu_result_d = w_op_a << w_shamt;
      c_ALU_SLT:  alu_result_d = {31'h0, $signed(w_op_a) < $signed(w_op_b)};
      c_ALU_SLTU: alu_result_d = {31'h0, w_op_a < w_op_b};
      c_ALU_XOR:  alu_result_d = w_op_a ^ w_op_b;
      c_ALU_SRL:  alu_result_d = w_op_a >> w_shamt;
      c_ALU_SRA:  alu_result_d = $unsigned($signed(w_op_a) >>> w_shamt);
      c_ALU_OR:   alu_result_d = w_op_a | w_op_b;
      c_ALU_AND:  alu_result_d = w_op_a & w_op_b;
      default:    alu_result_d = 32'h0;
    endcase
  end

  // Compare runs on every instruction; the core qualifies it with the opcode
  always_comb begin
    branch_taken_d = 1'b0;
    case (w_funct3)
      3'b000:  branch_taken_d = (rs1_val_i == rs2_val_i);
      3'b001:  branch_taken_d = (rs1_val_i != rs2_val_i);
      3'b100:  branch_taken_d = ($signed(rs1_val_i) <  $signed(rs2_val_i));
      3'b101:  branch_taken_d = ($signed(rs1_val_i) >= $signed(rs2_val_i));
      3'b110:  branch_taken_d = (rs1_val_i <  rs2_val_i);
      3'b111:  branch_taken_d = (rs1_val_i >= rs2_val_i);
      default: branch_taken_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q   <= 32'h0;
      branch_taken_q <= 1'b0;
    end else begin
      alu_result_q   <= alu_result_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  assign opcode_o       = w_opcode;
  assign alu_op_o       = w_alu_op;
  assign invalid_o      = w_invalid;
  assign rd_o           = insn_i[11:7];
  assign rs1_o          = insn_i[19:15];
  assign rs2_o          = insn_i[24:20];
  assign imm_o          = w_imm;
  assign alu_result_o   = alu_result_q;
  assign branch_taken_o = branch_taken_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_decode_exec_unit.sv
// ============================================================================
// tb_rv32i_decode_exec_unit -- directed vectors, reset sequence, random vs. model
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_rv32i_decode_exec_unit;

  logic        clk;
  logic        rst;
  logic [31:0] insn, rs1_val, rs2_val;
  logic [4:0]  opcode, rd, rs1, rs2;
  logic [3:0]  alu_op;
  logic        invalid;
  logic [31:0] imm, alu_result;
  logic        branch_taken;

  int total = 0;
  int bad   = 0;

  rv32i_decode_exec_unit dut (
    .clk            (clk),
    .rst            (rst),
    .insn_i         (insn),
    .rs1_val_i      (rs1_val),
    .rs2_val_i      (rs2_val),
    .opcode_o       (opcode),
    .alu_op_o       (alu_op),
    .invalid_o      (invalid),
    .rd_o           (rd),
    .rs1_o          (rs1),
    .rs2_o          (rs2),
    .imm_o          (imm),
    .alu_result_o   (alu_result),
    .branch_taken_o (branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] insn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  opc;
    logic [4:0]  rd;
    logic [3:0]  aop;
    logic        inv;
    logic [31:0] imm;
    logic [31:0] res;
    logic        tkn;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=0x%08h req=0x%08h", name, act, exp);
    end
  endtask

  // Reference model, straight from the ISA rules
  function automatic bit m_is_itype(input logic [4:0] o);
    return o == 5'b00000 || o == 5'b00100 || o == 5'b11001 || o == 5'b11100;
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    logic [4:0] o = i[6:2];
    int v;
    if (m_is_itype(o)) v = $signed(i) >>> 20;
    else if (o == 5'b01000) v = ($signed(i) >>> 25) * 32 + int'(i[11:7]);
    else if (o == 5'b11000)
      v = ($signed(i) >>> 31) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    else if (o == 5'b00101 || o == 5'b01101) v = int'(i & 32'hFFFFF000);
    else if (o == 5'b11011)
      v = ($signed(i) >>> 31) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
          + int'(i[30:21]) * 2;
    else v = 0;
    return v;
  endfunction

  function automatic logic m_invalid(input logic [31:0] i);
    logic [4:0] o = i[6:2];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    if (i[1:0] != 2'b11) return 1'b1;
    case (o)
      5'b00000, 5'b00011, 5'b00101, 5'b01000, 5'b01101, 5'b11001, 5'b11011, 5'b11100: return 1'b0;
      5'b11000: return f3 inside {3'b010, 3'b011};
      5'b01100: return !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'b000, 3'b101}));
      5'b00100: return (f3 == 3'b001 && f7 != 0) || (f3 == 3'b101 && !(f7 inside {7'h00, 7'h20}));
      default:  return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] m_aluop(input logic [31:0] i);
    if (i[6:2] == 5'b01100) return {i[30], i[14:12]};
    if (i[6:2] == 5'b00100) return {i[30] && i[14:12] == 3'b101, i[14:12]};
    return 4'b0000;
  endfunction

  function automatic logic [31:0] m_result(input logic [31:0] i, input logic [31:0] r1,
                                           input logic [31:0] r2);
    logic [4:0]  o = i[6:2];
    logic [31:0] a = (o == 5'b01101) ? 32'h0 : r1;
    logic [31:0] b;
    longint      sa, sb;
    int          sh;
    if (o inside {5'b00100, 5'b01101, 5'b00000, 5'b01000}) b = m_imm(i);
    else if (o == 5'b11001) b = 32'h0;
    else b = r2;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (m_aluop(i))
      4'b0000: return 32'(a + b);
      4'b1000: return 32'(a - b);
      4'b0001: return 32'(a * (64'd1 << sh));
      4'b0010: return {31'h0, sa < sb};
      4'b0011: return {31'h0, a < b};
      4'b0100: return a ^ b;
      4'b0101: return a / (32'd1 << sh);
      4'b1101: return 32'(sa >>> sh);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return sa < sb;
      3'b101: return sa >= sb;
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    insn = i; rs1_val = a; rs2_val = b;
    #1;
  endtask

  vec_t vecs[13];
  logic [4:0] opc_list[11] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                               5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};

  initial begin
    //           insn          rs1           rs2         opc       rd    aop      inv   imm           res           tkn
    vecs[0]  = '{32'h00500093, 32'h0,        32'h0,      5'b00100, 5'd1, 4'b0000, 1'b0, 32'h5,        32'h5,        1'b1};
    vecs[1]  = '{32'h402080B3, 32'h7,        32'h9,      5'b01100, 5'd1, 4'b1000, 1'b0, 32'h0,        32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{32'h4040D093, 32'h80000000, 32'h0,      5'b00100, 5'd1, 4'b1101, 1'b0, 32'h404,      32'hF8000000, 1'b0};
    vecs[3]  = '{32'h0040D093, 32'h80000000, 32'h0,      5'b00100, 5'd1, 4'b0101, 1'b0, 32'h4,        32'h08000000, 1'b0};
    vecs[4]  = '{32'h00208463, 32'h3,        32'h3,      5'b11000, 5'd8, 4'b0000, 1'b0, 32'h8,        32'h6,        1'b1};
    vecs[5]  = '{32'h00208463, 32'h3,        32'h4,      5'b11000, 5'd8, 4'b0000, 1'b0, 32'h8,        32'h7,        1'b0};
    vecs[6]  = '{32'h0020C463, 32'hFFFFFFFF, 32'h1,      5'b11000, 5'd8, 4'b0000, 1'b0, 32'h8,        32'h0,        1'b1};
    vecs[7]  = '{32'h0020E463, 32'hFFFFFFFF, 32'h1,      5'b11000, 5'd8, 4'b0000, 1'b0, 32'h8,        32'h0,        1'b0};
    vecs[8]  = '{32'hFFDFF0EF, 32'h0,        32'h0,      5'b11011, 5'd1, 4'b0000, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1};
    vecs[9]  = '{32'h00000000, 32'h11,       32'h11,     5'b00000, 5'd0, 4'b0000, 1'b1, 32'h0,        32'h11,       1'b1};
    vecs[10] = '{32'h123450B7, 32'hDEAD,     32'h0,      5'b01101, 5'd1, 4'b0000, 1'b0, 32'h12345000, 32'h12345000, 1'b1};
    vecs[11] = '{32'h00C08067, 32'h1000,     32'h5,      5'b11001, 5'd0, 4'b0000, 1'b0, 32'hC,        32'h1000,     1'b0};
    vecs[12] = '{32'h402090B3, 32'h5,        32'h1,      5'b01100, 5'd1, 4'b1001, 1'b1, 32'h0,        32'h0,        1'b1};

    rst = 1'b1; insn = 32'h00500093; rs1_val = 32'h0; rs2_val = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", alu_result, 32'h0);
    chk("reset_taken", {31'h0, branch_taken}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].insn, vecs[k].a, vecs[k].b);
      chk($sformatf("v%0d_opcode", k), {27'h0, opcode}, {27'h0, vecs[k].opc});
      chk($sformatf("v%0d_rd", k), {27'h0, rd}, {27'h0, vecs[k].rd});
      chk($sformatf("v%0d_aluop", k), {28'h0, alu_op}, {28'h0, vecs[k].aop});
      chk($sformatf("v%0d_invalid", k), {31'h0, invalid}, {31'h0, vecs[k].inv});
      chk($sformatf("v%0d_imm", k), imm, vecs[k].imm);
      @(posedge clk); #1;
      chk($sformatf("v%0d_result", k), alu_result, vecs[k].res);
      chk($sformatf("v%0d_taken", k), {31'h0, branch_taken}, {31'h0, vecs[k].tkn});
    end

    // Reset mid-op beats a simultaneous update, then the pipeline resumes
    drive(32'h00500093, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("seq_pre_result", alu_result, 32'h5);
    @(negedge clk);
    rst = 1'b1; insn = 32'h00A00093; rs1_val = 32'h0; rs2_val = 32'h0;
    @(posedge clk); #1;
    chk("seq_rst_result", alu_result, 32'h0);
    chk("seq_rst_taken", {31'h0, branch_taken}, 32'h0);
    chk("seq_rst_imm_comb", imm, 32'hA);
    @(posedge clk); #1;
    chk("seq_rst_hold", alu_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("seq_resume_result", alu_result, 32'hA);
    chk("seq_resume_taken", {31'h0, branch_taken}, 32'h1);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ri, ra, rb;
      ri = $urandom;
      if ($urandom_range(0, 9) != 0) ri[6:2] = opc_list[$urandom_range(0, 10)];
      if ($urandom_range(0, 9) != 0) ri[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) ri[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      drive(ri, ra, rb);
      chk("rnd_opcode", {27'h0, opcode}, {27'h0, ri[6:2]});
      chk("rnd_rd", {27'h0, rd}, {27'h0, ri[11:7]});
      chk("rnd_rs1", {27'h0, rs1}, {27'h0, ri[19:15]});
      chk("rnd_rs2", {27'h0, rs2}, {27'h0, ri[24:20]});
      chk("rnd_aluop", {28'h0, alu_op}, {28'h0, m_aluop(ri)});
      chk("rnd_invalid", {31'h0, invalid}, {31'h0, m_invalid(ri)});
      chk("rnd_imm", imm, m_imm(ri));
      @(posedge clk); #1;
      chk("rnd_result", alu_result, m_result(ri, ra, rb));
      chk("rnd_taken", {31'h0, branch_taken}, {31'h0, m_taken(ri[14:12], ra, rb)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
